// File: rtl/reg_file_dump.sv
// Sequential register-file reader: on start, walks FIRST_REG..LAST_REG through one read port
// and streams each word on a valid/ready interface. Optional macro: REG_DUMP_CHECKSUM_EN.
module reg_file_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_addr,
    output logic        out_last
);
    localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
    localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, STREAM, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, STREAM} state_t;
`endif

    state_t      state_reg, state_next;
    logic [4:0]  ptr_reg, ptr_next;
    logic        loaded_all_reg, loaded_all_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        valid_reg, valid_next;
    logic [31:0] data_reg, data_next;
    logic [4:0]  addr_reg, addr_next;
    logic        last_reg, last_next;
    logic        load;
    logic        accept;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [31:0] acc_reg, acc_next;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            ptr_reg        <= FIRST_ADDR;
            loaded_all_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            valid_reg      <= 1'b0;
            data_reg       <= '0;
            addr_reg       <= '0;
            last_reg       <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            acc_reg        <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            loaded_all_reg <= loaded_all_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            valid_reg      <= valid_next;
            data_reg       <= data_next;
            addr_reg       <= addr_next;
            last_reg       <= last_next;
`ifdef REG_DUMP_CHECKSUM_EN
            acc_reg        <= acc_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        loaded_all_next = loaded_all_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        valid_next      = valid_reg;
        data_next       = data_reg;
        addr_next       = addr_reg;
        last_next       = last_reg;
`ifdef REG_DUMP_CHECKSUM_EN
        acc_next        = acc_reg;
`endif
        accept = valid_reg && out_ready;
        load   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    ptr_next        = FIRST_ADDR;
                    loaded_all_next = 1'b0;
                    state_next      = STREAM;
                    busy_next       = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    acc_next        = '0;
`endif
                end
            end
            STREAM: begin
                // The output slot refills whenever it is empty or being drained this cycle.
                load = (!valid_reg || out_ready) && !loaded_all_reg;
                if (load) begin
                    data_next  = rd_data;
                    addr_next  = ptr_reg;
                    valid_next = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    last_next  = 1'b0;
                    acc_next   = acc_reg ^ rd_data;
`else
                    last_next  = (ptr_reg == LAST_ADDR);
`endif
                    if (ptr_reg == LAST_ADDR) begin
                        loaded_all_next = 1'b1;
                    end else begin
                        ptr_next = ptr_reg + 5'd1;
                    end
                end else if (accept) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    // Once everything is loaded, the beat in flight is LAST_REG; swap in the checksum.
                    if (loaded_all_reg) begin
                        state_next = CSUM;
                        data_next  = acc_reg;
                        addr_next  = 5'd0;
                        last_next  = 1'b1;
                        valid_next = 1'b1;
                    end else begin
                        valid_next = 1'b0;
                    end
`else
                    valid_next = 1'b0;
                    if (last_reg) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        last_next  = 1'b0;
                    end
`endif
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    valid_next = 1'b0;
                    last_next  = 1'b0;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rd_addr   = ptr_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_addr  = addr_reg;
    assign out_last  = last_reg;

endmodule

// File: tb/tb_reg_file_dump.sv
// Self-checking bench for reg_file_dump: full-range instance (0..31) and single-register instance (3..3).
`timescale 1ns/1ps
module tb_reg_file_dump;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int NV = 32 + CS;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] reg_val;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, done, out_valid, out_last;
    logic [4:0]  rd_addr, out_addr;
    logic [31:0] rd_data, out_data;
    logic [31:0] rf_a [32];

    logic        start_b = 1'b0;
    logic        out_ready_b = 1'b0;
    logic        busy_b, done_b, out_valid_b, out_last_b;
    logic [4:0]  rd_addr_b, out_addr_b;
    logic [31:0] rd_data_b, out_data_b;
    logic [31:0] rf_b [32];

    assign rd_data   = rf_a[rd_addr];
    assign rd_data_b = rf_b[rd_addr_b];

    always #5 clk = ~clk;

    reg_file_dump #(.FIRST_REG(0), .LAST_REG(31)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
    );

    reg_file_dump #(.FIRST_REG(3), .LAST_REG(3)) dut_single (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .out_addr(out_addr_b), .out_last(out_last_b)
    );

    int    n_checks = 0;
    int    n_pass = 0;
    vec_t  vec_tab [NV];
    beat_t exp_q [$];
    beat_t got_q [$];
    int    done_cnt, first_valid_c, done_c, last_acc_c;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Reference model: the dump is simply the register range in order, plus an XOR word when enabled.
    task automatic build_expected(input int first, input int last, input bit use_b);
        logic [31:0] acc;
        beat_t b;
        acc = '0;
        exp_q.delete();
        for (int a = first; a <= last; a++) begin
            b.addr = 5'(a);
            b.data = use_b ? rf_b[a] : rf_a[a];
            b.last = (a == last) && (CS == 0);
            acc ^= b.data;
            exp_q.push_back(b);
        end
        if (CS == 1) begin
            b.addr = 5'd0;
            b.data = acc;
            b.last = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    task automatic compare_beats(input string tag);
        check($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(got_q[i].addr), 32'(exp_q[i].addr));
            check($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s_last%0d", tag, i), 32'(got_q[i].last), 32'(exp_q[i].last));
        end
    endtask

    // mode 0: ready high; 1: random ready; 2: 3-cycle stall at address 5; 3: extra start at beat 10
    task automatic run_dump(input int mode, input int max_cycles);
        int    hold;
        bit    stalled, restarted;
        beat_t b;
        hold = 0; stalled = 0; restarted = 0;
        got_q.delete();
        done_cnt = 0; first_valid_c = -1; done_c = -1; last_acc_c = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int c = 0; c < max_cycles; c++) begin
            start = 1'b0;
            if (mode == 3 && !restarted && got_q.size() == 10) begin
                start = 1'b1;
                restarted = 1;
            end
            case (mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (!stalled && out_valid && out_addr == 5'd5) begin
                        hold = 3;
                        stalled = 1;
                    end
                    out_ready = (hold == 0);
                    if (hold > 0) begin
                        check("stall_data", out_data, 32'h55);
                        check("stall_addr", 32'(out_addr), 32'd5);
                        hold--;
                    end
                end
                default: out_ready = 1'b1;
            endcase
            if (out_valid && first_valid_c < 0) first_valid_c = c;
            if (done) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
            end
            if (out_valid && !out_ready && got_q.size() < exp_q.size()) begin
                check("held_addr", 32'(out_addr), 32'(exp_q[got_q.size()].addr));
                check("held_data", out_data, exp_q[got_q.size()].data);
            end
            if (out_valid && out_ready) begin
                b.addr = out_addr; b.data = out_data; b.last = out_last;
                got_q.push_back(b);
                last_acc_c = c;
                $display("beat %0d addr=%0d data=%08h last=%0b", got_q.size() - 1, b.addr, b.data, b.last);
            end
            if (done_c >= 0 && c >= done_c + 3) break;
            tick();
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (done_c < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    k;
        int    done_seen;
        logic [31:0] xacc;
        beat_t b;

        xacc = '0;
        for (int i = 0; i < 32; i++) begin
            vec_tab[i].reg_val  = 32'(i) * 32'h11;
            vec_tab[i].exp_addr = 5'(i);
            vec_tab[i].exp_data = 32'(i) * 32'h11;
            vec_tab[i].exp_last = (i == 31) && (CS == 0);
            xacc ^= vec_tab[i].reg_val;
        end
`ifdef REG_DUMP_CHECKSUM_EN
        vec_tab[32].reg_val  = '0;
        vec_tab[32].exp_addr = 5'd0;
        vec_tab[32].exp_data = xacc;
        vec_tab[32].exp_last = 1'b1;
`endif
        for (int i = 0; i < 32; i++) begin
            rf_a[i] = vec_tab[i].reg_val;
            rf_b[i] = $urandom;
        end
        rf_b[3] = 32'hDEADBEEF;

        // reset state
        rst = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_rd_addr_single", 32'(rd_addr_b), 32'd3);
        check("rst_valid_single", 32'(out_valid_b), 32'd0);
        rst = 1'b1;
        tick();

        // full dump with ready held high, compared against the vector table
        build_expected(0, 31, 0);
        run_dump(0, 100);
        $display("dump full: beats=%0d first_valid=%0d done_at=%0d", got_q.size(), first_valid_c, done_c);
        check("first_valid_latency", 32'(first_valid_c), 32'd1);
        check("done_latency", 32'(done_c), 32'(NV + 1));
        check("done_after_last", 32'(done_c), 32'(last_acc_c + 1));
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("tab_count", 32'(got_q.size()), 32'(NV));
        for (int i = 0; i < NV && i < got_q.size(); i++) begin
            check($sformatf("tab_addr%0d", i), 32'(got_q[i].addr), 32'(vec_tab[i].exp_addr));
            check($sformatf("tab_data%0d", i), got_q[i].data, vec_tab[i].exp_data);
            check($sformatf("tab_last%0d", i), 32'(got_q[i].last), 32'(vec_tab[i].exp_last));
        end

        // backpressure on address 5
        run_dump(2, 100);
        $display("dump backpressure: beats=%0d", got_q.size());
        compare_beats("bp");
        check("bp_done_pulses", 32'(done_cnt), 32'd1);

        // start while busy
        run_dump(3, 100);
        $display("dump start_while_busy: beats=%0d", got_q.size());
        compare_beats("sb");
        check("sb_done_pulses", 32'(done_cnt), 32'd1);

        // reset mid-dump at beat 7
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (!(out_valid && out_addr == 5'd7) && k < 50) begin
            tick();
            k++;
        end
        check("reach_beat7", 32'(out_addr), 32'd7);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) done_seen++;
        end
        check("mid_rst_no_done", 32'(done_seen), 32'd0);
        $display("reset mid-dump applied");
        run_dump(0, 100);
        compare_beats("restart");
        check("restart_done_pulses", 32'(done_cnt), 32'd1);

        // random contents and random out_ready
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) rf_a[i] = $urandom;
            build_expected(0, 31, 0);
            run_dump(1, 400);
            $display("dump random %0d: beats=%0d", r, got_q.size());
            compare_beats($sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_done_pulses", r), 32'(done_cnt), 32'd1);
        end

        // checksum pattern
        for (int i = 0; i < 32; i++) rf_a[i] = '0;
        rf_a[1] = 32'hF0F0F0F0;
        rf_a[2] = 32'h0F0F0F0F;
        build_expected(0, 31, 0);
        run_dump(0, 100);
        $display("dump checksum pattern: beats=%0d", got_q.size());
        compare_beats("cs");
`ifdef REG_DUMP_CHECKSUM_EN
        check("cs_beats", 32'(got_q.size()), 32'd33);
        if (got_q.size() == 33) begin
            check("cs_word", got_q[32].data, 32'hFFFFFFFF);
            check("cs_addr", 32'(got_q[32].addr), 32'd0);
            check("cs_last", 32'(got_q[32].last), 32'd1);
        end
`endif

        // single-register instance
        build_expected(3, 3, 1);
        got_q.delete();
        done_seen = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        out_ready_b = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (done_b) done_seen++;
            if (out_valid_b && out_ready_b) begin
                b.addr = out_addr_b; b.data = out_data_b; b.last = out_last_b;
                got_q.push_back(b);
                $display("single beat %0d addr=%0d data=%08h last=%0b", got_q.size() - 1, b.addr, b.data, b.last);
            end
            tick();
        end
        out_ready_b = 1'b0;
        compare_beats("single");
        check("single_done_pulses", 32'(done_seen), 32'd1);
        if (got_q.size() > 0) begin
            check("single_addr", 32'(got_q[0].addr), 32'd3);
            check("single_data", got_q[0].data, 32'hDEADBEEF);
            check("single_last", 32'(got_q[0].last), 32'(1 - CS));
        end else begin
            check("single_present", 32'd0, 32'd1);
        end
        check("single_busy_end", 32'(busy_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
